// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: states, hazard causes and control patterns for pipe_stall_ctrl (perf counters under PIPE_PERF_CNT_EN)
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {RUN, MDU_WAIT, MEM_WAIT} state_e;
   typedef enum logic [2:0] {
      CAUSE_NONE,
      CAUSE_LOAD_USE,
      CAUSE_REDIRECT,
      CAUSE_MDU,
      CAUSE_MDU_HOLD,
      CAUSE_MEM,
      CAUSE_RESET
   } cause_e;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;
   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_write;
      logic idex_bubble;
      logic exmem_write;
      logic exmem_bubble;
      logic memwb_bubble;
      logic mdu_start;
   } ctrl_t;
   function automatic ctrl_t ctrl_for(cause_e c);
      case (c)
         CAUSE_RESET:    return ctrl_t'(9'b001010110);
         CAUSE_MEM:      return ctrl_t'(9'b000000010);
         CAUSE_MDU:      return ctrl_t'(9'b000001101);
         CAUSE_MDU_HOLD: return ctrl_t'(9'b000001100);
         CAUSE_REDIRECT: return ctrl_t'(9'b111111000);
         CAUSE_LOAD_USE: return ctrl_t'(9'b000111000);
         default:        return ctrl_t'(9'b110101000);
      endcase
   endfunction
endpackage

// File: rtl/pipe_perf_counters.sv
// pipe_perf_counters: wrapping stall-cycle and redirect-flush counters
module pipe_perf_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);
   logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
   // next counts: add one per qualifying event
   always_comb begin
      stall_d = stall_q + CNT_W'(stall);
      flush_d = flush_q + CNT_W'(flush);
   end
   // counter registers, cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end
   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush scheduler for the 5-stage pipeline (PIPE_PERF_CNT_EN enables perf counters)
module pipe_stall_ctrl #(
   parameter int REGW        = 5,
   parameter int MDU_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REGW-1:0]  id_rs1,
   input  logic [REGW-1:0]  id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             idex_mem_rd,
   input  logic [REGW-1:0]  idex_rd,
   input  logic             ex_redirect,
   input  logic             ex_mdu_op,
   input  logic             mdu_done,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_bubble,
   output logic             exmem_write,
   output logic             exmem_bubble,
   output logic             memwb_bubble,
   output logic             mdu_start,
   output logic             mdu_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);
   import pipe_ctrl_pkg::*;
   localparam int TW = $clog2(MDU_TIMEOUT);
   state_e        state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          fin_q, fin_d, drop_q, drop_d, tmo_q, tmo_d;
   logic          mem_wait, load_use, mdu_new, mdu_end, tmo_hit, adv;
   cause_e        cause;
   ctrl_t         ctrl;
   // fin_q marks a finished MDU op still sitting in EX so it is not restarted;
   // drop_q turns that op into a bubble when it was aborted by timeout
   always_comb begin
      mem_wait = dmem_req & ~dmem_ready;
      load_use = id_valid & idex_mem_rd & (idex_rd != '0) &
                 ((id_use_rs1 & (id_rs1 == idex_rd)) | (id_use_rs2 & (id_rs2 == idex_rd)));
      mdu_new  = ex_mdu_op & ~fin_q;
      tmo_hit  = (state_q == MDU_WAIT) & ~mdu_done & (cnt_q == TW'(MDU_TIMEOUT - 1));
      mdu_end  = mdu_done | tmo_hit;
      adv      = (state_q == RUN) & ~rst & ~mem_wait & ~(mdu_new & ~mdu_done);
      cause    = rst                   ? CAUSE_RESET
               : state_q == MEM_WAIT   ? CAUSE_MEM
               : state_q == MDU_WAIT   ? CAUSE_MDU_HOLD
               : mem_wait              ? CAUSE_MEM
               : mdu_new & ~mdu_done   ? CAUSE_MDU
               : ex_redirect           ? CAUSE_REDIRECT
               : load_use              ? CAUSE_LOAD_USE
               :                         CAUSE_NONE;
      ctrl = ctrl_for(cause);
      ctrl.mdu_start    = ctrl.mdu_start | (adv & mdu_new);
      ctrl.exmem_bubble = ctrl.exmem_bubble | (adv & drop_q);
      state_d = state_q == RUN      ? (mem_wait ? MEM_WAIT : (mdu_new & ~mdu_done) ? MDU_WAIT : RUN)
              : state_q == MDU_WAIT ? (mdu_end ? RUN : MDU_WAIT)
              :                       (dmem_ready ? RUN : MEM_WAIT);
      cnt_d  = (state_q == MDU_WAIT & ~mdu_end) ? cnt_q + TW'(1) : '0;
      fin_d  = (state_q == MDU_WAIT & mdu_end) | (fin_q & ~adv);
      drop_d = tmo_hit | (drop_q & ~adv);
      tmo_d  = tmo_q | tmo_hit;
   end
   // state, wait counter and sticky flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
         fin_q   <= 1'b0;
         drop_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fin_q   <= fin_d;
         drop_q  <= drop_d;
         tmo_q   <= tmo_d;
      end
   end
   assign {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_write, exmem_bubble, memwb_bubble, mdu_start} = ctrl;
   assign mdu_timeout = tmo_q;
`ifdef PIPE_PERF_CNT_EN
   logic stall_ev, flush_ev;
   assign stall_ev = ~ctrl.pc_write & ~rst;
   assign flush_ev = cause == CAUSE_REDIRECT;
   pipe_perf_counters #(.CNT_W(CNT_W)) u_perf (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall_ev),
      .flush        (flush_ev),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif
endmodule
